// File: rtl/rv32f_fpu_scheduler.sv
// rv32f_fpu_scheduler: issue and writeback scheduler for the RV32F FP_OP units.
// Pipelined ops reserve a slot in one shared writeback port; the iterative DIV
// result is buffered and slotted into free cycles, with starvation protection.
// Optional perf counters: define RV32F_FPU_SCHED_PERF_EN.
module rv32f_fpu_scheduler #(
  parameter int unsigned TAG_W      = 5,
  parameter int unsigned ADD_LAT    = 3,
  parameter int unsigned MUL_LAT    = 4,
  parameter int unsigned MISC_LAT   = 1,
  parameter int unsigned DIV_STARVE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [6:0]       issue_funct7,
  input  logic [2:0]       issue_funct3,
  input  logic [TAG_W-1:0] issue_tag,
  output logic             add_start,
  output logic             mul_start,
  output logic             misc_start,
  output logic             div_start,
  input  logic             div_busy,
  input  logic             div_done,
  output logic             illegal_op,
  output logic             wb_valid,
  output logic [1:0]       wb_unit,
  output logic [TAG_W-1:0] wb_tag
`ifdef RV32F_FPU_SCHED_PERF_EN
  ,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_div_wait_cnt
`endif
);

  localparam int unsigned MAX_AM  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int unsigned MAX_LAT = (MAX_AM > MISC_LAT) ? MAX_AM : MISC_LAT;
  localparam int unsigned SC_W    = $clog2(DIV_STARVE + 1);

  typedef enum logic [1:0] {
    UNIT_ADD  = 2'd0,
    UNIT_MUL  = 2'd1,
    UNIT_MISC = 2'd2,
    UNIT_DIV  = 2'd3
  } unit_e;

  typedef enum logic [2:0] {CLS_ADD, CLS_MUL, CLS_MISC, CLS_DIV, CLS_ILL} op_cls_e;

  // res_*[i] describes the writeback occurring i+1 cycles from now
  logic [MAX_LAT-1:0] res_valid;
  unit_e              res_unit [MAX_LAT];
  logic [TAG_W-1:0]   res_tag  [MAX_LAT];

  logic               div_buf_valid;
  logic               div_pending;
  logic [TAG_W-1:0]   div_tag;
  logic [SC_W-1:0]    starve_cnt;
  logic               starve_block;

  op_cls_e            op_cls;
  logic               is_pipe;
  int unsigned        pipe_lat;
  unit_e              pipe_unit;
  logic               slot_busy;
  logic               hs;
  logic               nxt_pipe_v;
  unit_e              nxt_unit;
  logic [TAG_W-1:0]   nxt_tag;
  logic               div_drain;

  logic               unused_funct3;
  assign unused_funct3 = ^issue_funct3;

  // Classify the incoming op by funct7
  always_comb begin
    op_cls = CLS_ILL;
    case (issue_funct7)
      7'b0000000, 7'b0000100: op_cls = CLS_ADD;
      7'b0001000:             op_cls = CLS_MUL;
      7'b0001100, 7'b0101100: op_cls = CLS_DIV;
      7'b0010000, 7'b0010100, 7'b1100000, 7'b1110000,
      7'b1010000, 7'b1101000, 7'b1111000: op_cls = CLS_MISC;
      default:                op_cls = CLS_ILL;
    endcase
  end

  // Latency of a pipelined op and whether its writeback slot is already taken
  always_comb begin
    is_pipe   = 1'b1;
    pipe_lat  = ADD_LAT;
    pipe_unit = UNIT_ADD;
    case (op_cls)
      CLS_ADD:  ;
      CLS_MUL:  begin pipe_lat = MUL_LAT;  pipe_unit = UNIT_MUL;  end
      CLS_MISC: begin pipe_lat = MISC_LAT; pipe_unit = UNIT_MISC; end
      default:  is_pipe = 1'b0;
    endcase
    slot_busy = 1'b0;
    for (int unsigned i = 0; i < MAX_LAT; i++) begin
      if (i + 1 == pipe_lat && res_valid[i]) slot_busy = 1'b1;
    end
  end

  assign starve_block = (starve_cnt == SC_W'(DIV_STARVE));

  // Accept rules per op class; illegal ops are always swallowed
  always_comb begin
    case (op_cls)
      CLS_DIV: issue_ready = !div_busy && !div_buf_valid && !div_pending;
      CLS_ILL: issue_ready = 1'b1;
      default: issue_ready = !slot_busy && !starve_block;
    endcase
  end

  assign hs         = issue_valid && issue_ready;
  assign add_start  = hs && (op_cls == CLS_ADD);
  assign mul_start  = hs && (op_cls == CLS_MUL);
  assign misc_start = hs && (op_cls == CLS_MISC);
  assign div_start  = hs && (op_cls == CLS_DIV);
  assign illegal_op = hs && (op_cls == CLS_ILL);

  // Pipelined result due next cycle; a latency-1 op issued now bypasses the shift register
  always_comb begin
    nxt_pipe_v = res_valid[0];
    nxt_unit   = res_unit[0];
    nxt_tag    = res_tag[0];
    if (hs && is_pipe && pipe_lat == 1) begin
      nxt_pipe_v = 1'b1;
      nxt_unit   = pipe_unit;
      nxt_tag    = issue_tag;
    end
  end

  assign div_drain = div_buf_valid && !nxt_pipe_v;

  // Advance the reservation window and insert newly issued pipelined ops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= '0;
      for (int unsigned i = 0; i < MAX_LAT; i++) begin
        res_unit[i] <= UNIT_ADD;
        res_tag[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i + 1 < MAX_LAT; i++) begin
        res_valid[i] <= res_valid[i+1];
        res_unit[i]  <= res_unit[i+1];
        res_tag[i]   <= res_tag[i+1];
      end
      res_valid[MAX_LAT-1] <= 1'b0;
      for (int unsigned i = 0; i < MAX_LAT; i++) begin
        if (hs && is_pipe && i + 2 == pipe_lat) begin
          res_valid[i] <= 1'b1;
          res_unit[i]  <= pipe_unit;
          res_tag[i]   <= issue_tag;
        end
      end
    end
  end

  // Registered writeback port: pipelined reservation first, else the DIV buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_unit  <= 2'd0;
      wb_tag   <= '0;
    end else if (nxt_pipe_v) begin
      wb_valid <= 1'b1;
      wb_unit  <= nxt_unit;
      wb_tag   <= nxt_tag;
    end else if (div_buf_valid) begin
      wb_valid <= 1'b1;
      wb_unit  <= UNIT_DIV;
      wb_tag   <= div_tag;
    end else begin
      wb_valid <= 1'b0;
      wb_unit  <= 2'd0;
      wb_tag   <= '0;
    end
  end

  // DIV bookkeeping: outstanding flag, result buffer and starvation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_pending   <= 1'b0;
      div_tag       <= '0;
      div_buf_valid <= 1'b0;
      starve_cnt    <= '0;
    end else begin
      if (div_start) begin
        div_pending <= 1'b1;
        div_tag     <= issue_tag;
      end else if (div_done) begin
        div_pending <= 1'b0;
      end
      if (div_done)       div_buf_valid <= 1'b1;
      else if (div_drain) div_buf_valid <= 1'b0;
      if (div_drain)                         starve_cnt <= '0;
      else if (div_buf_valid && !starve_block) starve_cnt <= starve_cnt + 1'b1;
    end
  end

`ifdef RV32F_FPU_SCHED_PERF_EN
  // Saturating stall and DIV-wait counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt    <= '0;
      perf_div_wait_cnt <= '0;
    end else begin
      if (issue_valid && !issue_ready && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (div_buf_valid && !div_drain && perf_div_wait_cnt != '1)
        perf_div_wait_cnt <= perf_div_wait_cnt + 32'd1;
    end
  end
`endif

  a_div_done_proto: assert property (@(posedge clk) disable iff (!rst_n) !(div_done && div_buf_valid));

endmodule

// File: tb/tb_rv32f_fpu_scheduler.sv
// Directed testbench for rv32f_fpu_scheduler (default parameters).
module tb_rv32f_fpu_scheduler;

  logic       clk;
  logic       rst_n;
  logic       issue_valid;
  logic       issue_ready;
  logic [6:0] issue_funct7;
  logic [2:0] issue_funct3;
  logic [4:0] issue_tag;
  logic       add_start, mul_start, misc_start, div_start;
  logic       div_busy, div_done;
  logic       illegal_op;
  logic       wb_valid;
  logic [1:0] wb_unit;
  logic [4:0] wb_tag;
`ifdef RV32F_FPU_SCHED_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_div_wait_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [6:0] F_ADD  = 7'b0000000;
  localparam logic [6:0] F_MUL  = 7'b0001000;
  localparam logic [6:0] F_DIV  = 7'b0001100;
  localparam logic [6:0] F_SGNJ = 7'b0010000;
  localparam logic [6:0] F_CLS  = 7'b1110000;
  localparam logic [6:0] F_FMA  = 7'b1000011;

  rv32f_fpu_scheduler #(
    .TAG_W(5), .ADD_LAT(3), .MUL_LAT(4), .MISC_LAT(1), .DIV_STARVE(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_funct7(issue_funct7), .issue_funct3(issue_funct3), .issue_tag(issue_tag),
    .add_start(add_start), .mul_start(mul_start), .misc_start(misc_start), .div_start(div_start),
    .div_busy(div_busy), .div_done(div_done), .illegal_op(illegal_op),
    .wb_valid(wb_valid), .wb_unit(wb_unit), .wb_tag(wb_tag)
`ifdef RV32F_FPU_SCHED_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_div_wait_cnt(perf_div_wait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into the first cycle after reset release
  task automatic apply_reset();
    issue_valid = 1'b0; issue_funct7 = F_ADD; issue_funct3 = 3'd0; issue_tag = 5'd0;
    div_busy = 1'b0; div_done = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    issue_valid = 1'b0; issue_funct7 = F_ADD; issue_funct3 = 3'd0; issue_tag = 5'd0;
    div_busy = 1'b0; div_done = 1'b0;
    rst_n = 1'b0;
    #3;
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%0b exp=0", wb_valid); end
    checks++; if (wb_unit !== 2'd0) begin failures++; $display("FAIL reset_wb_unit got=%0d exp=0", wb_unit); end
    checks++; if (wb_tag !== 5'd0) begin failures++; $display("FAIL reset_wb_tag got=%0d exp=0", wb_tag); end
    checks++; if ({add_start, mul_start, misc_start, div_start, illegal_op} !== 5'b0) begin
      failures++; $display("FAIL reset_starts got=%05b exp=00000", {add_start, mul_start, misc_start, div_start, illegal_op}); end
    apply_reset();
    #2;
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", issue_ready); end
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL post_reset_wb_valid got=%0b exp=0", wb_valid); end
  endtask

  task automatic test_add_basic();
    apply_reset();
    issue_valid = 1'b1; issue_funct7 = F_ADD; issue_tag = 5'd3;
    #2;
    checks++; if (add_start !== 1'b1) begin failures++; $display("FAIL add_start got=%0b exp=1", add_start); end
    checks++; if ({mul_start, misc_start, div_start, illegal_op} !== 4'b0) begin
      failures++; $display("FAIL add_other_starts got=%04b exp=0000", {mul_start, misc_start, div_start, illegal_op}); end
    for (int c = 1; c <= 4; c++) begin
      cyc();
      issue_valid = 1'b0;
      #2;
      checks++; if (wb_valid !== (c == 3)) begin failures++; $display("FAIL add_wb_valid c=%0d got=%0b exp=%0b", c, wb_valid, (c == 3)); end
      if (c == 3) begin
        checks++; if (wb_unit !== 2'd0 || wb_tag !== 5'd3) begin
          failures++; $display("FAIL add_wb unit/tag got=%0d/%0d exp=0/3", wb_unit, wb_tag); end
      end
    end
  endtask

  task automatic test_mul_add_collision();
    apply_reset();
    issue_valid = 1'b1; issue_funct7 = F_MUL; issue_tag = 5'd1;
    #2;
    checks++; if (mul_start !== 1'b1) begin failures++; $display("FAIL coll_mul_start got=%0b exp=1", mul_start); end
    cyc();
    issue_funct7 = F_ADD; issue_tag = 5'd2;
    #2;
    checks++; if (issue_ready !== 1'b0 || add_start !== 1'b0) begin
      failures++; $display("FAIL coll_stall ready/start got=%0b/%0b exp=0/0", issue_ready, add_start); end
    cyc();
    #2;
    checks++; if (issue_ready !== 1'b1 || add_start !== 1'b1) begin
      failures++; $display("FAIL coll_issue ready/start got=%0b/%0b exp=1/1", issue_ready, add_start); end
    for (int c = 3; c <= 6; c++) begin
      cyc();
      issue_valid = 1'b0;
      #2;
      checks++; if (wb_valid !== (c == 4 || c == 5)) begin
        failures++; $display("FAIL coll_wb_valid c=%0d got=%0b exp=%0b", c, wb_valid, (c == 4 || c == 5)); end
      if (c == 4) begin
        checks++; if (wb_unit !== 2'd1 || wb_tag !== 5'd1) begin
          failures++; $display("FAIL coll_wb_mul unit/tag got=%0d/%0d exp=1/1", wb_unit, wb_tag); end
      end
      if (c == 5) begin
        checks++; if (wb_unit !== 2'd0 || wb_tag !== 5'd2) begin
          failures++; $display("FAIL coll_wb_add unit/tag got=%0d/%0d exp=0/2", wb_unit, wb_tag); end
      end
    end
`ifdef RV32F_FPU_SCHED_PERF_EN
    checks++; if (perf_stall_cnt !== 32'd1) begin failures++; $display("FAIL perf_stall_cnt got=%0d exp=1", perf_stall_cnt); end
`endif
  endtask

  task automatic test_misc();
    apply_reset();
    issue_valid = 1'b1; issue_funct7 = F_ADD; issue_tag = 5'd4;   // lands t3
    #2;
    cyc(); issue_valid = 1'b0; #2;
    cyc(); issue_valid = 1'b1; issue_funct7 = F_SGNJ; issue_tag = 5'd9;
    #2;
    checks++; if (issue_ready !== 1'b0 || misc_start !== 1'b0) begin
      failures++; $display("FAIL misc_blocked ready/start got=%0b/%0b exp=0/0", issue_ready, misc_start); end
    cyc();
    #2;
    checks++; if (misc_start !== 1'b1) begin failures++; $display("FAIL misc_start got=%0b exp=1", misc_start); end
    checks++; if (wb_valid !== 1'b1 || wb_unit !== 2'd0 || wb_tag !== 5'd4) begin
      failures++; $display("FAIL misc_t3_wb v/unit/tag got=%0b/%0d/%0d exp=1/0/4", wb_valid, wb_unit, wb_tag); end
    cyc();
    issue_funct7 = F_CLS; issue_tag = 5'd12;
    #2;
    checks++; if (misc_start !== 1'b1) begin failures++; $display("FAIL fclass_start got=%0b exp=1", misc_start); end
    checks++; if (wb_valid !== 1'b1 || wb_unit !== 2'd2 || wb_tag !== 5'd9) begin
      failures++; $display("FAIL misc_t4_wb v/unit/tag got=%0b/%0d/%0d exp=1/2/9", wb_valid, wb_unit, wb_tag); end
    cyc();
    issue_valid = 1'b0;
    #2;
    checks++; if (wb_valid !== 1'b1 || wb_unit !== 2'd2 || wb_tag !== 5'd12) begin
      failures++; $display("FAIL misc_t5_wb v/unit/tag got=%0b/%0d/%0d exp=1/2/12", wb_valid, wb_unit, wb_tag); end
    cyc();
    #2;
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL misc_t6_wb got=%0b exp=0", wb_valid); end
  endtask

  task automatic test_illegal();
    int wb_seen;
    apply_reset();
    issue_valid = 1'b1; issue_funct7 = F_FMA; issue_tag = 5'd5;
    #2;
    checks++; if (issue_ready !== 1'b1 || illegal_op !== 1'b1) begin
      failures++; $display("FAIL illegal ready/flag got=%0b/%0b exp=1/1", issue_ready, illegal_op); end
    checks++; if ({add_start, mul_start, misc_start, div_start} !== 4'b0) begin
      failures++; $display("FAIL illegal_starts got=%04b exp=0000", {add_start, mul_start, misc_start, div_start}); end
    wb_seen = 0;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      issue_valid = 1'b0;
      #2;
      if (c == 1) begin
        checks++; if (illegal_op !== 1'b0) begin failures++; $display("FAIL illegal_pulse got=%0b exp=0", illegal_op); end
      end
      if (wb_valid === 1'b1) wb_seen++;
    end
    checks++; if (wb_seen != 0) begin failures++; $display("FAIL illegal_no_wb got=%0d exp=0", wb_seen); end
  endtask

  task automatic test_div_starve();
    logic       exp_rdy, exp_v;
    logic [1:0] exp_u;
    logic [4:0] exp_t;
    apply_reset();
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) cyc();
      div_busy = (c >= 1 && c <= 4);
      div_done = (c == 5);
      if (c == 0) begin
        issue_valid = 1'b1; issue_funct7 = F_DIV; issue_tag = 5'd7;
      end else if (c == 1) begin
        issue_valid = 1'b0; issue_funct7 = F_DIV;
      end else if (c <= 13) begin
        issue_valid = 1'b1; issue_funct7 = F_ADD;
        issue_tag = (c <= 9) ? 5'(c + 8) : 5'd18;
      end else begin
        issue_valid = 1'b0;
      end
      #2;
      if (c == 0) begin
        checks++; if (div_start !== 1'b1) begin failures++; $display("FAIL div_start got=%0b exp=1", div_start); end
      end
      if (c == 1) begin
        checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL div_second_ready got=%0b exp=0", issue_ready); end
      end
      if (c >= 2 && c <= 13) begin
        exp_rdy = (c <= 9 || c == 13);
        checks++; if (issue_ready !== exp_rdy || add_start !== exp_rdy) begin
          failures++; $display("FAIL starve_ready c=%0d ready/start got=%0b/%0b exp=%0b", c, issue_ready, add_start, exp_rdy); end
      end
      exp_v = 1'b0; exp_u = 2'd0; exp_t = 5'd0;
      if (c >= 5 && c <= 12) begin exp_v = 1'b1; exp_t = 5'(c + 5); end
      if (c == 13) begin exp_v = 1'b1; exp_u = 2'd3; exp_t = 5'd7; end
      if (c == 16) begin exp_v = 1'b1; exp_t = 5'd18; end
      checks++; if (wb_valid !== exp_v) begin failures++; $display("FAIL starve_wb_valid c=%0d got=%0b exp=%0b", c, wb_valid, exp_v); end
      if (exp_v) begin
        checks++; if (wb_unit !== exp_u || wb_tag !== exp_t) begin
          failures++; $display("FAIL starve_wb c=%0d unit/tag got=%0d/%0d exp=%0d/%0d", c, wb_unit, wb_tag, exp_u, exp_t); end
      end
    end
`ifdef RV32F_FPU_SCHED_PERF_EN
    checks++; if (perf_div_wait_cnt !== 32'd6) begin failures++; $display("FAIL perf_div_wait_cnt got=%0d exp=6", perf_div_wait_cnt); end
`endif
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    issue_valid = 1'b1; issue_funct7 = F_DIV; issue_tag = 5'd4;
    #2;
    checks++; if (div_start !== 1'b1) begin failures++; $display("FAIL mid_div_start got=%0b exp=1", div_start); end
    cyc(); div_busy = 1'b1; issue_funct7 = F_ADD; issue_tag = 5'd1; #2;
    checks++; if (add_start !== 1'b1) begin failures++; $display("FAIL mid_add1_start got=%0b exp=1", add_start); end
    cyc(); issue_tag = 5'd2; #2;
    checks++; if (add_start !== 1'b1) begin failures++; $display("FAIL mid_add2_start got=%0b exp=1", add_start); end
    cyc(); issue_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (wb_valid !== 1'b0 || issue_ready !== 1'b1) begin
      failures++; $display("FAIL mid_in_reset wb/ready got=%0b/%0b exp=0/1", wb_valid, issue_ready); end
    cyc(); rst_n = 1'b1; div_busy = 1'b0;
    for (int c = 4; c <= 9; c++) begin
      if (c > 4) cyc();
      issue_valid = (c == 6);
      issue_funct7 = (c == 5) ? F_DIV : F_ADD;
      issue_tag = 5'd6;
      #2;
      if (c == 5) begin
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL mid_div_ready got=%0b exp=1", issue_ready); end
      end
      if (c == 6) begin
        checks++; if (add_start !== 1'b1) begin failures++; $display("FAIL mid_new_add got=%0b exp=1", add_start); end
      end
      checks++; if (wb_valid !== (c == 9)) begin failures++; $display("FAIL mid_wb_valid c=%0d got=%0b exp=%0b", c, wb_valid, (c == 9)); end
      if (c == 9) begin
        checks++; if (wb_unit !== 2'd0 || wb_tag !== 5'd6) begin
          failures++; $display("FAIL mid_wb unit/tag got=%0d/%0d exp=0/6", wb_unit, wb_tag); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_basic();
    test_mul_add_collision();
    test_misc();
    test_illegal();
    test_div_starve();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
